// File: rtl/out_uart_pkg.sv
// Shared types and constants for the CPU output-port UART.
// OUT_UART_PARITY_EN adds an even-parity bit to every frame (8E1 instead of 8N1).
package out_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef OUT_UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

`ifdef OUT_UART_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif

endpackage

// File: rtl/out_fifo.sv
// Synchronous word FIFO with first-word-fall-through read.
// A push while full is accepted when a pop happens in the same cycle.
module out_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; empty/full come from the counter alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/out_port_uart.sv
// Buffers 16-bit CPU output words and sends each as two UART frames, low byte first.
// Define OUT_UART_PARITY_EN for 8E1 framing; default is 8N1.
module out_port_uart
    import out_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_valid,
    input  logic        overflow_clr,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    state_e          state_q, state_d;
    logic [15:0]     hold_q, hold_d;
    logic            byte_sel_q, byte_sel_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_q, tx_d;
    logic            overflow_q, overflow_d;

    logic        fifo_empty, fifo_pop, fifo_push, bit_done, drop;
    logic [15:0] fifo_dout;
    logic [7:0]  cur_byte_d;

    // The CPU cannot stall: a word is lost only if the FIFO is full and not draining this cycle.
    assign fifo_push = din_valid & (~fifo_full | fifo_pop);
    assign drop      = din_valid & fifo_full & ~fifo_pop;

    out_fifo #(
        .Width (16),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        byte_sel_d = byte_sel_q;
        bit_idx_d  = bit_idx_q;
        fifo_pop   = 1'b0;
        bit_done   = (cnt_q == CntMax);
        cnt_d      = (state_q == StIdle || bit_done) ? '0 : cnt_q + CntW'(1);

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    hold_d     = fifo_dout;
                    byte_sel_d = 1'b0;
                    bit_idx_d  = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef OUT_UART_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // tx is registered, so its next value follows the next state.
        cur_byte_d = byte_sel_d ? hold_d[15:8] : hold_d[7:0];
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = cur_byte_d[bit_idx_d];
`ifdef OUT_UART_PARITY_EN
            StParity: tx_d = ^cur_byte_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        overflow_d = drop | (overflow_q & ~overflow_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            byte_sel_q <= 1'b0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            byte_sel_q <= byte_sel_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_out_port_uart.sv
// Scoreboard bench for out_port_uart: a monitor decodes tx frames and checks them
// against bytes queued by the stimulus, plus directed timing and flag checks.
module tb_out_port_uart;
    import out_uart_pkg::*;

    localparam int unsigned Cpb   = 4;
    localparam int unsigned Depth = 8;
    localparam int unsigned FrameCyc = FrameBits * Cpb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        tx, busy, fifo_full, overflow;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          drive_cyc;
    logic [7:0]  exp_q [$];
    int          starts [$];

    out_port_uart #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .overflow_clr (overflow_clr),
        .tx           (tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [15:0] w, input bit expect_tx);
        @(negedge clk);
        drive_cyc = cyc;
        din       = w;
        din_valid = 1'b1;
        if (expect_tx) begin
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int i = 0; i < budget && starts.size() < n; i++) @(negedge clk);
        check("frames_started", starts.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        check("drained_busy", busy, 1'b0);
        check("drained_queue", exp_q.size(), 0);
    endtask

    // Monitor: sample each bit at its first negedge; abort quietly on reset.
    logic [10:0] fb;
    logic [7:0]  mon_exp;
    bit          mon_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                mon_abort = 1'b0;
                fb = '0;
                for (int i = 0; i < int'(FrameBits) - 1; i++) begin
                    for (int j = 0; j < int'(Cpb); j++) begin
                        @(negedge clk);
                        if (rst) mon_abort = 1'b1;
                    end
                    if (mon_abort) break;
                    fb[i] = tx;
                end
                if (!mon_abort) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got byte %02h expected no frame", fb[7:0]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (fb[7:0] !== mon_exp || fb[FrameBits-2] !== 1'b1) begin
                            errors++;
                            $display("FAIL frame_byte: got %02h stop %b expected %02h stop 1",
                                     fb[7:0], fb[FrameBits-2], mon_exp);
                        end
`ifdef OUT_UART_PARITY_EN
                        else if (fb[8] !== ^mon_exp) begin
                            errors++;
                            $display("FAIL frame_parity: got %b expected %b for %02h",
                                     fb[8], ^mon_exp, mon_exp);
                        end
`endif
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int s0;
    int bad_tx;
    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word: latency, byte spacing, busy release.
        starts.delete();
        drive(16'hA55A, 1'b1);
        s0 = drive_cyc;
        release_valid();
        wait_starts(2, 200);
        if (starts.size() >= 2) begin
            check("latency", starts[0] - s0, 2);
            check("byte_spacing", starts[1] - starts[0], FrameCyc);
            while (cyc < starts[0] + 2 * int'(FrameCyc) - 1) @(negedge clk);
            check("busy_last_stop", busy, 1'b1);
            @(negedge clk);
            check("busy_fall", busy, 1'b0);
            check("tx_idle", tx, 1'b1);
        end
        wait_idle(200);

        // Back-to-back words: one idle cycle between words.
        starts.delete();
        drive(16'h0001, 1'b1);
        drive(16'h8000, 1'b1);
        release_valid();
        wait_starts(4, 400);
        if (starts.size() >= 4) begin
            check("word_gap", starts[2] - starts[0], 2 * FrameCyc + 1);
            check("word2_hi", starts[3] - starts[2], FrameCyc);
        end
        wait_idle(400);

        // Parity-bearing word (parity checked by the monitor in the parity build).
        drive(16'h0701, 1'b1);
        release_valid();
        wait_idle(400);

        // Overflow burst: 10 words on consecutive cycles, the 10th is dropped.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 8) check("full_before", fifo_full, 1'b0);
            if (i == 9) begin
                check("full_after8", fifo_full, 1'b1);
                check("ovf_before", overflow, 1'b0);
            end
            din       = 16'h1100 + 16'(i * 16'h0111);
            din_valid = 1'b1;
            if (i < 9) begin
                exp_q.push_back(din[7:0]);
                exp_q.push_back(din[15:8]);
            end
        end
        @(negedge clk);
        check("ovf_set", overflow, 1'b1);
        check("full_hold", fifo_full, 1'b1);
        din          = 16'hDEAD;
        din_valid    = 1'b1;
        overflow_clr = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", overflow, 1'b1);
        din_valid = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 1'b0);
        overflow_clr = 1'b0;
        wait_idle(2000);

        // Reset in the middle of the low byte's data bits.
        starts.delete();
        drive(16'h3C3C, 1'b0);
        release_valid();
        wait_starts(1, 50);
        repeat (3 * Cpb) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        bad_tx = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
        end
        check("postrst_tx_low_cycles", bad_tx, 0);
        check("postrst_busy", busy, 1'b0);
        check("leftover_expect", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
